// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 datapath blocks.
// Holds the write-back FSM state type and the byte-reversal helper.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

    localparam int SHA256_DIGEST_WIDTH = 256;

    // Widest word the byte-reversal helper can handle.
    localparam int BSWAP_MAX_WIDTH = 512;

    // Reverses the lowest num_bytes bytes of word; the remaining upper bytes come back zero.
    function automatic logic [BSWAP_MAX_WIDTH-1:0] bswap_word(
        input logic [BSWAP_MAX_WIDTH-1:0] word,
        input int                         num_bytes
    );
        logic [BSWAP_MAX_WIDTH-1:0] swapped;
        swapped = '0;
        for (int b = 0; b < BSWAP_MAX_WIDTH / 8; b++) begin
            if (b < num_bytes) begin
                swapped[b*8 +: 8] = word[(num_bytes-1-b)*8 +: 8];
            end else begin
                swapped[b*8 +: 8] = 8'h00;
            end
        end
        return swapped;
    endfunction

endpackage

// File: rtl/hash_word_select.sv
// Combinational digest word mux: picks word i in LS-first or MS-first order,
// optionally reversing the bytes of the chosen word.
module hash_word_select
    import sha256_pkg::*;
#(
    parameter int DIGEST_WIDTH = SHA256_DIGEST_WIDTH,
    parameter int WORD_WIDTH   = 32
) (
    input  logic [DIGEST_WIDTH-1:0]                                           i_digest,
    input  logic [((DIGEST_WIDTH/WORD_WIDTH) > 1 ? $clog2(DIGEST_WIDTH/WORD_WIDTH) : 1)-1:0] i_idx,
    input  logic                                                              i_word_order,
    input  logic                                                              i_byte_swap,
    output logic [WORD_WIDTH-1:0]                                             o_word
);

    localparam int NUM_WORDS = DIGEST_WIDTH / WORD_WIDTH;
    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [IDX_WIDTH-1:0]  w_sel_idx;
    logic [WORD_WIDTH-1:0] w_word;
    logic [WORD_WIDTH-1:0] w_swapped;

    // Word mux (one-hot OR of all slices) followed by the optional byte reversal.
    always_comb begin
        w_sel_idx = i_word_order ? (IDX_WIDTH'(NUM_WORDS - 1) - i_idx) : i_idx;
        w_word    = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            w_word = w_word | ((IDX_WIDTH'(k) == w_sel_idx) ?
                               i_digest[k*WORD_WIDTH +: WORD_WIDTH] : '0);
        end
        w_swapped = WORD_WIDTH'(bswap_word(BSWAP_MAX_WIDTH'(w_word), WORD_WIDTH / 8));
        o_word    = i_byte_swap ? w_swapped : w_word;
    end

endmodule

// File: rtl/hash_writeback.sv
// Digest write-out engine: captures a finished digest on start and streams it
// word by word over a valid/ready memory write port, then pulses done.
module hash_writeback
    import sha256_pkg::*;
#(
    parameter int DIGEST_WIDTH = SHA256_DIGEST_WIDTH,
    parameter int WORD_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DIGEST_WIDTH-1:0] digest,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    word_order,
    input  logic                    byte_swap,
    input  logic                    mem_ready,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_data,
    output logic                    busy,
    output logic                    done
);

    localparam int NUM_WORDS = DIGEST_WIDTH / WORD_WIDTH;
    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    wb_state_t               r_state;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic [DIGEST_WIDTH-1:0] r_digest;
    logic [ADDR_WIDTH-1:0]   r_base_addr;
    logic                    r_word_order;
    logic                    r_byte_swap;
    logic                    r_mem_write;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [WORD_WIDTH-1:0]   r_mem_data;
    logic                    r_busy;
    logic                    r_done;

    wb_state_t               w_next_state;
    logic [IDX_WIDTH-1:0]    w_next_idx;
    logic                    w_capture;
    logic                    w_accept;
    logic [DIGEST_WIDTH-1:0] w_src_digest;
    logic [ADDR_WIDTH-1:0]   w_src_base;
    logic                    w_src_order;
    logic                    w_src_swap;
    logic [WORD_WIDTH-1:0]   w_word;

    assign w_accept = r_mem_write && mem_ready;

    // Next-state and word index logic.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = WRITE;
                    w_next_idx   = '0;
                    w_capture    = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                if (w_accept && (r_idx == LAST_IDX)) begin
                    w_next_state = DONE;
                end else if (w_accept) begin
                    w_next_idx   = r_idx + IDX_WIDTH'(1);
                end else begin
                    w_next_state = WRITE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_idx   = '0;
            end
        endcase
    end

    // Outputs are registered, so the cycle that captures must see the live inputs.
    always_comb begin
        w_src_digest = w_capture ? digest     : r_digest;
        w_src_base   = w_capture ? base_addr  : r_base_addr;
        w_src_order  = w_capture ? word_order : r_word_order;
        w_src_swap   = w_capture ? byte_swap  : r_byte_swap;
    end

    hash_word_select #(
        .DIGEST_WIDTH (DIGEST_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_word_select (
        .i_digest     (w_src_digest),
        .i_idx        (w_next_idx),
        .i_word_order (w_src_order),
        .i_byte_swap  (w_src_swap),
        .o_word       (w_word)
    );

    // State, capture and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_digest     <= '0;
            r_base_addr  <= '0;
            r_word_order <= 1'b0;
            r_byte_swap  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            if (w_capture) begin
                r_digest     <= digest;
                r_base_addr  <= base_addr;
                r_word_order <= word_order;
                r_byte_swap  <= byte_swap;
            end
            r_mem_write <= (w_next_state == WRITE);
            r_mem_addr  <= (w_next_state == WRITE) ? (w_src_base + ADDR_WIDTH'(w_next_idx)) : '0;
            r_mem_data  <= (w_next_state == WRITE) ? w_word : '0;
            r_busy      <= (w_next_state != IDLE);
            r_done      <= (w_next_state == DONE);
        end
    end

    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
